trap_controller: RTL and testbench
==================================

TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-003 SHALL have port address_exception, input, 1, out-of-range data address flag from the address check stage.
REQ-004 SHALL have port illegal_inst, input, 1, illegal-instruction flag from decode.
REQ-005 SHALL have port ecall_sig, input, 1, environment-call flag from decode.
REQ-006 SHALL have port mret_sig, input, 1, trap-return request.
REQ-007 SHALL have port exc_pc, input, 32, PC of the faulting instruction.
REQ-008 SHALL have port exc_addr, input, 32, offending data address.
REQ-009 SHALL have port mtvec, input, 32, trap vector base; bits [1:0] ignored.
REQ-010 SHALL have port exception_sig, output, 1, one-cycle pulse announcing trap acceptance, fed back to clear the fault sources.
REQ-011 SHALL have port flush, output, 1, pipeline flush.
REQ-012 SHALL have port trap_busy, output, 1, high in every non-IDLE state; upstream stalls on it.
REQ-013 SHALL have port pc_redirect, output, 1, one-cycle PC load strobe.
REQ-014 SHALL have port redirect_pc, output, 32, PC target, valid while pc_redirect is high.
REQ-015 SHALL have ports mepc, mcause and mtval, output, 32 each, holding saved trap PC, cause and value.

Function
REQ-016 SHALL run a state machine with states IDLE, FLUSH, SAVE, REDIRECT and RETURN.
REQ-017 SHALL treat a trap request as the OR of illegal_inst, ecall_sig and address_exception, sampled only in IDLE.
REQ-018 SHALL resolve simultaneous sources by priority illegal_inst (cause 2) > ecall_sig (cause 11) > address_exception (cause 5).
REQ-019 SHALL, when a trap is accepted in IDLE on cycle N, pulse exception_sig and enter FLUSH at N+1, latching the cause, exc_pc and exc_addr into internal registers at N+1.
REQ-020 SHALL, in FLUSH, assert flush for exactly one cycle and then enter SAVE.
REQ-021 SHALL, in SAVE, write mepc = latched PC and mcause = cause (zero-extended); mtval = latched exc_addr for cause 5, otherwise 0; then enter REDIRECT.
REQ-022 SHALL, in REDIRECT, assert pc_redirect for one cycle with redirect_pc per REQ-029/030, then return to IDLE, giving a trap latency of 3 cycles from acceptance to redirect.
REQ-023 SHALL, when mret_sig is high in IDLE and no trap request is present, assert flush for one cycle by entering RETURN; the cycle after that, pulse pc_redirect with redirect_pc = mepc and return to IDLE.
REQ-024 SHALL drop mret_sig when it coincides with a trap request (the trap wins).
REQ-025 SHALL ignore all trap and mret requests outside IDLE (no nesting, no queuing).
REQ-026 SHALL hold mepc, mcause and mtval constant except in SAVE.

Reset
REQ-027 SHALL, on reset in any state (including mid-trap), return to IDLE the next edge and drive exception_sig, flush, trap_busy and pc_redirect to 0, and redirect_pc, mepc, mcause, mtval and the latched registers to 0.
REQ-028 SHALL give reset priority over every request in the same cycle.

Configuration
REQ-029 SHALL, with macro TRAP_VECTORED_EN defined, set redirect_pc = {mtvec[31:2],2'b00} + 4*cause, wrapping modulo 2^32.
REQ-030 SHALL, without TRAP_VECTORED_EN, set redirect_pc = {mtvec[31:2],2'b00} for every cause.

Verification
REQ-031 SHALL cover: address_exception=1, exc_pc=0x100, exc_addr=0x900, mtvec=0x200 -> flush at N+1, mepc=0x100, mcause=5, mtval=0x900 at N+2, redirect_pc=0x200 at N+3 (0x214 with TRAP_VECTORED_EN).
REQ-032 SHALL cover: illegal_inst, ecall_sig and address_exception all high -> mcause=2, mtval=0.
REQ-033 SHALL cover: mret_sig with mepc=0x104 -> flush one cycle, then pc_redirect with redirect_pc=0x104.
REQ-034 SHALL cover: mret_sig and ecall_sig together -> trap taken with mcause=11, and no RETURN entered.
REQ-035 SHALL cover: reset asserted while in SAVE -> next cycle IDLE, all outputs 0, and no pc_redirect issued.
REQ-036 SHALL cover: a new address_exception arriving during FLUSH -> ignored, with mcause unchanged from the first trap.

Source files
------------

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: accepts exceptions and mret, saves mepc/mcause/mtval and redirects the PC.
// Build option TRAP_VECTORED_EN: trap target becomes {mtvec[31:2],2'b00} + 4*cause instead of the base alone.
module trap_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic        address_exception,
   input  logic        illegal_inst,
   input  logic        ecall_sig,
   input  logic        mret_sig,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_addr,
   input  logic [31:0] mtvec,
   output logic        exception_sig,
   output logic        flush,
   output logic        trap_busy,
   output logic        pc_redirect,
   output logic [31:0] redirect_pc,
   output logic [31:0] mepc,
   output logic [31:0] mcause,
   output logic [31:0] mtval
);

   // state    | meaning
   // IDLE     | waiting; samples trap and mret requests
   // FLUSH    | trap accepted; exception_sig and flush asserted
   // SAVE     | mepc/mcause/mtval hold the new trap record
   // REDIRECT | pc_redirect strobe (trap vector or mepc for a return)
   // RETURN   | mret accepted; flush asserted
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FLUSH    = 3'd1,
      SAVE     = 3'd2,
      REDIRECT = 3'd3,
      RETURN   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cause_q, cause_d;
   logic [31:0] pc_lat_q, pc_lat_d;
   logic [31:0] addr_lat_q, addr_lat_d;
   logic        ret_q, ret_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;

   logic        trap_req;
   logic [3:0]  trap_cause;
   logic [31:0] trap_target;

   assign trap_req = illegal_inst | ecall_sig | address_exception;

   always_comb begin
      trap_cause = 4'd5;
      if (illegal_inst)   trap_cause = 4'd2;
      else if (ecall_sig) trap_cause = 4'd11;
   end

`ifdef TRAP_VECTORED_EN
   assign trap_target = {mtvec[31:2], 2'b00} + {26'd0, cause_q, 2'b00};
`else
   assign trap_target = {mtvec[31:2], 2'b00};
`endif

   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      pc_lat_d   = pc_lat_q;
      addr_lat_d = addr_lat_q;
      ret_d      = ret_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      case (state_q)
         IDLE: begin
            if (trap_req) begin
               state_d    = FLUSH;
               cause_d    = trap_cause;
               pc_lat_d   = exc_pc;
               addr_lat_d = exc_addr;
               ret_d      = 1'b0;
            end else if (mret_sig) begin
               state_d = RETURN;
               ret_d   = 1'b1;
            end
         end
         FLUSH: begin
            // The trap record is written on the edge into SAVE so it is visible during SAVE.
            state_d  = SAVE;
            mepc_d   = pc_lat_q;
            mcause_d = {28'd0, cause_q};
            mtval_d  = (cause_q == 4'd5) ? addr_lat_q : 32'd0;
         end
         SAVE:     state_d = REDIRECT;
         RETURN:   state_d = REDIRECT;
         REDIRECT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cause_q    <= 4'd0;
         pc_lat_q   <= 32'd0;
         addr_lat_q <= 32'd0;
         ret_q      <= 1'b0;
         mepc_q     <= 32'd0;
         mcause_q   <= 32'd0;
         mtval_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         pc_lat_q   <= pc_lat_d;
         addr_lat_q <= addr_lat_d;
         ret_q      <= ret_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
      end
   end

   assign exception_sig = (state_q == FLUSH);
   assign flush         = (state_q == FLUSH) || (state_q == RETURN);
   assign trap_busy     = (state_q != IDLE);
   assign pc_redirect   = (state_q == REDIRECT);
   assign redirect_pc   = (state_q != REDIRECT) ? 32'd0 :
                          (ret_q ? mepc_q : trap_target);
   assign mepc          = mepc_q;
   assign mcause        = mcause_q;
   assign mtval         = mtval_q;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed corner cases plus random traps/returns against a trap-record model.
module tb_trap_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        address_exception, illegal_inst, ecall_sig, mret_sig;
   logic [31:0] exc_pc, exc_addr, mtvec;
   logic        exception_sig, flush, trap_busy, pc_redirect;
   logic [31:0] redirect_pc, mepc, mcause, mtval;

   int errors = 0;
   int checks = 0;

   // Architectural trap record as the bench expects it.
   logic [31:0] m_mepc, m_mcause, m_mtval;

   always #5 clk = ~clk;

   trap_controller dut (
      .clk(clk), .reset(reset),
      .address_exception(address_exception), .illegal_inst(illegal_inst),
      .ecall_sig(ecall_sig), .mret_sig(mret_sig),
      .exc_pc(exc_pc), .exc_addr(exc_addr), .mtvec(mtvec),
      .exception_sig(exception_sig), .flush(flush), .trap_busy(trap_busy),
      .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
      .mepc(mepc), .mcause(mcause), .mtval(mtval)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      address_exception = 1'b0;
      illegal_inst      = 1'b0;
      ecall_sig         = 1'b0;
      mret_sig          = 1'b0;
   endtask

   function automatic logic [31:0] exp_cause(input bit ill, input bit ec);
      if (ill) return 32'd2;
      if (ec)  return 32'd11;
      return 32'd5;
   endfunction

   function automatic logic [31:0] exp_target(input logic [31:0] tv, input logic [31:0] cause);
`ifdef TRAP_VECTORED_EN
      return (tv & 32'hFFFF_FFFC) + 32'd4 * cause;
`else
      return (tv & 32'hFFFF_FFFC) + 32'd0 * cause;
`endif
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, {31'd0, trap_busy}, 32'd0);
      check({tag, "_redir"}, {31'd0, pc_redirect}, 32'd0);
      check({tag, "_mepc"}, mepc, m_mepc);
      check({tag, "_mcause"}, mcause, m_mcause);
   endtask

   // One complete trap; noise drives fresh requests while the trap is in flight.
   task automatic do_trap(input bit ill, input bit ec, input bit ad, input bit mr,
                          input logic [31:0] pc, input logic [31:0] av,
                          input logic [31:0] tv, input bit noise);
      logic [31:0] cause;
      cause = exp_cause(ill, ec);
      illegal_inst = ill; ecall_sig = ec; address_exception = ad; mret_sig = mr;
      exc_pc = pc; exc_addr = av; mtvec = tv;
      step();
      check("flush_exc", {31'd0, exception_sig}, 32'd1);
      check("flush_flush", {31'd0, flush}, 32'd1);
      check("flush_busy", {31'd0, trap_busy}, 32'd1);
      check("flush_redir", {31'd0, pc_redirect}, 32'd0);
      check("flush_mepc_held", mepc, m_mepc);
      m_mepc   = pc;
      m_mcause = cause;
      m_mtval  = (cause == 32'd5) ? av : 32'd0;
      if (noise) begin
         address_exception = 1'b1;
         illegal_inst      = 1'($urandom_range(0, 1));
         mret_sig          = 1'b1;
         exc_pc            = $urandom;
         exc_addr          = $urandom;
      end else clear_req();
      step();
      check("save_flush", {31'd0, flush}, 32'd0);
      check("save_exc", {31'd0, exception_sig}, 32'd0);
      check("save_busy", {31'd0, trap_busy}, 32'd1);
      check("save_mepc", mepc, m_mepc);
      check("save_mcause", mcause, m_mcause);
      check("save_mtval", mtval, m_mtval);
      step();
      check("redir_strobe", {31'd0, pc_redirect}, 32'd1);
      check("redir_pc", redirect_pc, exp_target(tv, cause));
      check("redir_flush", {31'd0, flush}, 32'd0);
      clear_req();
      step();
      check_idle("post_trap");
      check("post_trap_mtval", mtval, m_mtval);
   endtask

   task automatic do_mret();
      mret_sig = 1'b1;
      step();
      check("ret_flush", {31'd0, flush}, 32'd1);
      check("ret_exc", {31'd0, exception_sig}, 32'd0);
      check("ret_busy", {31'd0, trap_busy}, 32'd1);
      check("ret_redir0", {31'd0, pc_redirect}, 32'd0);
      mret_sig = 1'b0;
      step();
      check("ret_strobe", {31'd0, pc_redirect}, 32'd1);
      check("ret_pc", redirect_pc, m_mepc);
      check("ret_flush1", {31'd0, flush}, 32'd0);
      step();
      check_idle("post_ret");
   endtask

   initial begin
      bit ill, ec, ad, mr;
      clear_req();
      exc_pc = 32'd0; exc_addr = 32'd0; mtvec = 32'd0;
      m_mepc = 32'd0; m_mcause = 32'd0; m_mtval = 32'd0;

      // Reset, and reset wins over a simultaneous request.
      reset = 1'b1;
      ecall_sig = 1'b1;
      step();
      step();
      check("rst_busy", {31'd0, trap_busy}, 32'd0);
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_exc", {31'd0, exception_sig}, 32'd0);
      check("rst_redir", {31'd0, pc_redirect}, 32'd0);
      check("rst_rpc", redirect_pc, 32'd0);
      check("rst_mepc", mepc, 32'd0);
      check("rst_mcause", mcause, 32'd0);
      check("rst_mtval", mtval, 32'd0);
      clear_req();
      reset = 1'b0;
      step();
      check_idle("idle0");

      // Address exception reference case.
      do_trap(1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h900, 32'h200, 1'b0);
      // All three sources: illegal instruction wins.
      do_trap(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h444, 32'h203, 1'b0);
      // Trap with mepc=0x104, then return.
      do_trap(1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h200, 1'b0);
      do_mret();
      // mret together with ecall: trap taken.
      do_trap(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 32'h0, 32'hFFFF_FFF0, 1'b0);
      // New address exception during FLUSH is ignored.
      do_trap(1'b0, 1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h400, 1'b1);

      // Reset while in SAVE.
      ecall_sig = 1'b1; exc_pc = 32'h700;
      step();
      clear_req();
      step();
      check("sv_busy", {31'd0, trap_busy}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_mepc = 32'd0; m_mcause = 32'd0; m_mtval = 32'd0;
      check("svrst_busy", {31'd0, trap_busy}, 32'd0);
      check("svrst_flush", {31'd0, flush}, 32'd0);
      check("svrst_redir", {31'd0, pc_redirect}, 32'd0);
      check("svrst_rpc", redirect_pc, 32'd0);
      check("svrst_mepc", mepc, 32'd0);
      check("svrst_mcause", mcause, 32'd0);
      check("svrst_mtval", mtval, 32'd0);
      step();
      check("svrst_noredir", {31'd0, pc_redirect}, 32'd0);
      check_idle("svrst_idle");

      // Random traffic.
      for (int i = 0; i < 40; i++) begin
         ill = ($urandom_range(0, 3) == 0);
         ec  = ($urandom_range(0, 3) == 0);
         ad  = ($urandom_range(0, 3) == 0);
         mr  = ($urandom_range(0, 2) == 0);
         if (ill || ec || ad)
            do_trap(ill, ec, ad, mr, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
         else if (mr)
            do_mret();
         else begin
            step();
            check_idle("rnd_idle");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
